// File: rtl/umips_fetch_stage.sv
// umips_fetch_stage: instruction-fetch stage of the 5-stage uMIPS pipeline.
//   Owns the PC, drives a req/ack instruction-memory port and loads the IF/ID register.
//   A 1-entry skid buffer catches a response that lands during a decode stall.
//   EX redirects override stall and ack; a request already in flight is finished and its data dropped.
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr  out  fetch request, held with stable address until imem_ack
//   imem_ack/imem_rdata in   response (may coincide with the request cycle)
//   stall               in   hold IF/ID
//   redirect_valid/_pc  in   taken branch/jump target (low two bits ignored)
//   if_id_valid/_instr/_pc4 out  IF/ID register
// Optional feature: define UMIPS_FETCH_PERF_EN to add perf_fetched / perf_bubbles counters.
module umips_fetch_stage #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [PC_WIDTH-1:0] imem_rdata,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                if_id_valid,
    output logic [PC_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0] if_id_pc4
`ifdef UMIPS_FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_bubbles
`endif
);

    localparam int unsigned W = PC_WIDTH;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        KILL = 3'd4
    } state_t;

    typedef struct packed {
        logic [W-1:0] instr;
        logic [W-1:0] pc4;
    } skid_t;

    state_t         state, state_nxt;
    logic [W-1:0]   pc, pc_nxt;
    logic [W-1:0]   addr_nxt;
    logic           req_nxt;
    logic           ifid_v_nxt;
    logic [W-1:0]   ifid_i_nxt, ifid_p_nxt;
    logic           skid_valid, skid_v_nxt;
    skid_t          skid, skid_nxt;
    logic           ack_live;
    logic           accept;
    logic [W-1:0]   pc_plus4;
    logic [W-1:0]   redirect_tgt;

    // State, PC, memory port, skid and IF/ID registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            skid_valid  <= 1'b0;
            skid        <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            imem_req    <= req_nxt;
            imem_addr   <= addr_nxt;
            if_id_valid <= ifid_v_nxt;
            if_id_instr <= ifid_i_nxt;
            if_id_pc4   <= ifid_p_nxt;
            skid_valid  <= skid_v_nxt;
            skid        <= skid_nxt;
        end
    end

    // Next-state, PC, skid and IF/ID update
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        ifid_v_nxt   = if_id_valid;
        ifid_i_nxt   = if_id_instr;
        ifid_p_nxt   = if_id_pc4;
        skid_v_nxt   = skid_valid;
        skid_nxt     = skid;
        ack_live     = imem_req & imem_ack;
        accept       = ack_live && (state != KILL) && !redirect_valid;
        pc_plus4     = pc + W'(4);
        redirect_tgt = redirect_pc & ~W'(3);

        if (redirect_valid) begin
            pc_nxt     = redirect_tgt;
            ifid_v_nxt = 1'b0;
            skid_v_nxt = 1'b0;
            // An unacked request must still complete; its data is discarded in KILL.
            state_nxt  = (imem_req && !imem_ack) ? KILL : REQ;
        end else begin
            // IF/ID: skid drains ahead of fresh data so ordering is preserved.
            if (!stall) begin
                if (skid_valid) begin
                    ifid_v_nxt = 1'b1;
                    ifid_i_nxt = skid.instr;
                    ifid_p_nxt = skid.pc4;
                    skid_v_nxt = 1'b0;
                end else if (accept) begin
                    ifid_v_nxt = 1'b1;
                    ifid_i_nxt = imem_rdata;
                    ifid_p_nxt = pc_plus4;
                end else begin
                    ifid_v_nxt = 1'b0;
                end
            end

            if (accept) begin
                pc_nxt = pc_plus4;
                if (stall || skid_valid) begin
                    skid_v_nxt = 1'b1;
                    skid_nxt   = '{instr: imem_rdata, pc4: pc_plus4};
                end
            end

            case (state)
                IDLE: state_nxt = REQ;
                REQ: begin
                    if (ack_live) state_nxt = skid_v_nxt ? HOLD : REQ;
                    else          state_nxt = skid_v_nxt ? HOLD : WAIT;
                end
                WAIT: begin
                    if (ack_live) state_nxt = skid_v_nxt ? HOLD : REQ;
                end
                HOLD: begin
                    if (!skid_v_nxt) state_nxt = REQ;
                end
                KILL: begin
                    if (ack_live) state_nxt = REQ;
                end
                default: state_nxt = IDLE;
            endcase
        end

        req_nxt  = (state_nxt == REQ) || (state_nxt == WAIT) || (state_nxt == KILL);
        // Address is frozen while a request is outstanding; otherwise it tracks the PC.
        addr_nxt = ((state_nxt == WAIT) || (state_nxt == KILL)) ? imem_addr : pc_nxt;
    end

`ifdef UMIPS_FETCH_PERF_EN
    // Fetched-instruction and decode-bubble counters, wrapping at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (accept) perf_fetched <= perf_fetched + 32'(1);
            if (!stall && !if_id_valid) perf_bubbles <= perf_bubbles + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_umips_fetch_stage.sv
// Directed testbench for umips_fetch_stage: zero-wait fetch, slow memory,
// stall/skid, redirects (with ack, during WAIT, wrap-around) and async reset.
module tb_umips_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
`ifdef UMIPS_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    logic zw;       // 1: memory acks in the request cycle
    logic ack_man;  // manual ack when zw = 0

    int n_pass  = 0;
    int n_total = 0;

    assign imem_ack   = zw ? imem_req : ack_man;
    assign imem_rdata = imem_addr;

    umips_fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4)
`ifdef UMIPS_FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    task automatic chk_port(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"},  {31'd0, imem_req}, {31'd0, req});
        chk({tag, ".addr"}, imem_addr, addr);
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] i, input logic [31:0] p);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
        chk({tag, ".instr"}, if_id_instr, i);
        chk({tag, ".pc4"},   if_id_pc4, p);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        zw = 1'b1; ack_man = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk_port("rst", 1'b0, 32'h0);
        chk_ifid("rst", 1'b0, 32'h0, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // 1: zero-wait memory
        step(); chk_port("t1.c1", 1'b1, 32'h0);  chk("t1.c1.valid", {31'd0, if_id_valid}, 32'd0);
        step(); chk_port("t1.c2", 1'b1, 32'h4);  chk_ifid("t1.c2", 1'b1, 32'h0, 32'h4);
        step(); chk_port("t1.c3", 1'b1, 32'h8);  chk_ifid("t1.c3", 1'b1, 32'h4, 32'h8);
        step(); chk_port("t1.c4", 1'b1, 32'hC);  chk_ifid("t1.c4", 1'b1, 32'h8, 32'hC);
        step(); chk_port("t1.c5", 1'b1, 32'h10); chk_ifid("t1.c5", 1'b1, 32'hC, 32'h10);

        // 2: three-cycle ack latency
        zw = 1'b0; ack_man = 1'b0;
        step(); chk_port("t2.w1", 1'b1, 32'h10); chk("t2.w1.valid", {31'd0, if_id_valid}, 32'd0);
        step(); chk_port("t2.w2", 1'b1, 32'h10); chk("t2.w2.valid", {31'd0, if_id_valid}, 32'd0);
        ack_man = 1'b1;
        step(); ack_man = 1'b0;
        chk_port("t2.a1", 1'b1, 32'h14); chk_ifid("t2.a1", 1'b1, 32'h10, 32'h14);
        step(); chk("t2.b1.valid", {31'd0, if_id_valid}, 32'd0);
        step(); chk("t2.b2.valid", {31'd0, if_id_valid}, 32'd0); chk_port("t2.b2", 1'b1, 32'h14);
        ack_man = 1'b1;
        step(); ack_man = 1'b0;
        chk_port("t2.a2", 1'b1, 32'h18); chk_ifid("t2.a2", 1'b1, 32'h14, 32'h18);

        // 3: stall while an ack arrives -> skid, HOLD, then drain in order
        zw = 1'b1; stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_port($sformatf("t3.s%0d", k), 1'b0, 32'h1C);
            chk_ifid($sformatf("t3.s%0d", k), 1'b1, 32'h14, 32'h18);
        end
        stall = 1'b0;
        step(); chk_ifid("t3.drain", 1'b1, 32'h18, 32'h1C); chk_port("t3.drain", 1'b1, 32'h1C);
        step(); chk_ifid("t3.next",  1'b1, 32'h1C, 32'h20); chk_port("t3.next",  1'b1, 32'h20);

        // 4: redirect coinciding with ack, unaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step(); redirect_valid = 1'b0;
        chk("t4.valid", {31'd0, if_id_valid}, 32'd0); chk_port("t4", 1'b1, 32'h100);
        step(); chk_ifid("t4.tgt", 1'b1, 32'h100, 32'h104);

        // 5: redirect during WAIT
        zw = 1'b0; ack_man = 1'b0;
        step(); chk_port("t5.wait", 1'b1, 32'h104);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step(); redirect_valid = 1'b0;
        chk_port("t5.kill1", 1'b1, 32'h104); chk("t5.kill1.valid", {31'd0, if_id_valid}, 32'd0);
        step(); chk_port("t5.kill2", 1'b1, 32'h104);
        ack_man = 1'b1;
        step(); ack_man = 1'b0;
        chk("t5.drop.valid", {31'd0, if_id_valid}, 32'd0); chk_port("t5.drop", 1'b1, 32'h200);
        zw = 1'b1;
        step(); chk_ifid("t5.tgt", 1'b1, 32'h200, 32'h204);

        // 6: redirect to top of address space, pc+4 wraps; async reset mid-WAIT
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); redirect_valid = 1'b0;
        chk_port("t6.redir", 1'b1, 32'hFFFF_FFFC);
        step(); chk_ifid("t6.wrap", 1'b1, 32'hFFFF_FFFC, 32'h0); chk_port("t6.wrap", 1'b1, 32'h0);
        zw = 1'b0; ack_man = 1'b0;
        step(); chk_port("t6.wait", 1'b1, 32'h0);
        ack_man = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk_port("t6.arst", 1'b0, 32'h0);
        chk_ifid("t6.arst", 1'b0, 32'h0, 32'h0);
        step(); step();
        ack_man = 1'b0; zw = 1'b1;
        reset = 1'b1;
        step(); chk_port("t6.idle", 1'b1, 32'h0); chk("t6.idle.valid", {31'd0, if_id_valid}, 32'd0);
        step(); chk_ifid("t6.restart", 1'b1, 32'h0, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
